// File: rtl/ifetch_pkg.sv
// Shared fetch-stage definitions: state encoding, word width, bubble encoding.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package ifetch_pkg;

    localparam int XLEN       = 32;
    localparam int INSN_BYTES = 4;

    // Decode treats an all-zero instruction word as "no instruction".
    localparam logic [XLEN-1:0] INSN_BUBBLE = 32'h0000_0000;

    typedef enum logic [0:0] {
        FETCH = 1'b0,   // issuing and receiving the four bytes of a word
        HOLD  = 1'b1    // word presented to decode, waiting to be taken
    } fetch_state_t;

    // Instructions are word aligned; redirect targets drop their low two bits.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
        return a & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/ifetch_if.sv
// Fetch-stage bundle: byte memory port, redirect input and the decode-side word.
// Latency: wires only.
// Backpressure: stall from decode, mem_busy from the memory arbiter.
interface ifetch_if;
    import ifetch_pkg::*;

    logic [XLEN-1:0] mem_a;
    logic            mem_rd;
    logic [7:0]      mem_din;
    logic            mem_busy;
    logic            stall;
    logic            br_take;
    logic [XLEN-1:0] br_target;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] is;
    logic            vld;

    // Fetch stage side.
    modport master (
        output mem_a, mem_rd, pc, is, vld,
        input  mem_din, mem_busy, stall, br_take, br_target
    );

    // Memory / decode / branch side.
    modport slave (
        input  mem_a, mem_rd, pc, is, vld,
        output mem_din, mem_busy, stall, br_take, br_target
    );

endinterface

// File: rtl/ifetch_asm.sv
// Little-endian 4-byte assembly register: one byte lane written per cycle, clearable.
// Latency: registered lanes; the word output also shows the lane being written this cycle.
// Backpressure: none; the owner decides when to write and clear.
module ifetch_asm
    import ifetch_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            we,
    input  logic [1:0]      lane,
    input  logic [7:0]      din,
    output logic [XLEN-1:0] word
);

    logic [XLEN-1:0] word_q;

    // Lane write; clear wins so a dropped word never leaks bytes into the next one.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            word_q <= '0;
        end else if (we) begin
            word_q[{lane, 3'b000} +: 8] <= din;
        end
    end

    // Merge the incoming byte so the final lane can go straight into the output register.
    always_comb begin
        word = word_q;
        if (we) begin
            word[{lane, 3'b000} +: 8] = din;
        end
    end

endmodule

// File: rtl/ifetch.sv
// RV32I fetch: reads a word as four byte requests, presents pc/is/vld to decode.
// Latency: 4 request cycles, last byte captured next cycle, vld the cycle after (6/insn steady).
// Backpressure: stall holds the presented word; mem_busy pauses issue; br_take restarts.
module ifetch
    import ifetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input logic      clk,
    input logic      rst,
    ifetch_if.master bus
);

    fetch_state_t    state;
    fetch_state_t    state_nxt;
    logic [2:0]      iss_cnt;    // bytes of the current word requested so far
    logic [1:0]      rcv_cnt;    // byte lane the next returning byte lands in
    logic            pend;       // a request went out last cycle; its byte is on mem_din
    logic [XLEN-1:0] fpc;        // address of the word being fetched
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] is_q;
    logic            vld_q;
    logic            issue;
    logic            cap;
    logic            cap_last;
    logic            consume;
    logic            redirect;
    logic [XLEN-1:0] asm_word;

    assign redirect = bus.br_take;

    // Per-cycle decisions and next state; a redirect overrides everything but reset.
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        cap       = 1'b0;
        cap_last  = 1'b0;
        consume   = 1'b0;
        case (state)
            FETCH: begin
                issue    = !rst && (iss_cnt < 3'd4) && !bus.mem_busy && !redirect;
                cap      = pend && !redirect;
                cap_last = cap && (rcv_cnt == 2'd3);
                if (cap_last) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                consume = !bus.stall && !redirect;
                if (consume) begin
                    state_nxt = FETCH;
                end
            end
            default: state_nxt = FETCH;
        endcase
        if (redirect) begin
            state_nxt = FETCH;
        end
    end

    assign bus.mem_rd = issue;
    assign bus.mem_a  = issue ? (fpc + {{(XLEN-3){1'b0}}, iss_cnt}) : '0;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Fetch address, issue/receive counters and the in-flight flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            fpc     <= RESET_PC;
            iss_cnt <= '0;
            rcv_cnt <= '0;
            pend    <= 1'b0;
        end else if (redirect) begin
            // The byte returning next cycle belongs to the old stream; pend=0 drops it.
            fpc     <= word_align(bus.br_target);
            iss_cnt <= '0;
            rcv_cnt <= '0;
            pend    <= 1'b0;
        end else if (consume) begin
            fpc     <= fpc + XLEN'(INSN_BYTES);
            iss_cnt <= '0;
            rcv_cnt <= '0;
            pend    <= 1'b0;
        end else begin
            pend <= issue;
            if (issue) begin
                iss_cnt <= iss_cnt + 3'd1;
            end
            if (cap) begin
                rcv_cnt <= rcv_cnt + 2'd1;
            end
        end
    end

    // Presented word; whenever vld is low the instruction is the bubble encoding.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q  <= RESET_PC;
            is_q  <= INSN_BUBBLE;
            vld_q <= 1'b0;
        end else if (redirect || consume) begin
            is_q  <= INSN_BUBBLE;
            vld_q <= 1'b0;
        end else if (cap_last) begin
            pc_q  <= fpc;
            is_q  <= asm_word;
            vld_q <= 1'b1;
        end
    end

    assign bus.pc  = pc_q;
    assign bus.is  = is_q;
    assign bus.vld = vld_q;

    ifetch_asm u_asm (
        .clk  (clk),
        .rst  (rst),
        .clr  (redirect || consume),
        .we   (cap),
        .lane (rcv_cnt),
        .din  (bus.mem_din),
        .word (asm_word)
    );

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: directed vector table, hand-written reset/wrap sequences, random run.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Backpressure: stall, mem_busy and br_take are driven by the bench.
module tb_ifetch;
    import ifetch_pkg::*;

    localparam logic [31:0] W0 = 32'h00A0_0513;  // bytes at 0x000
    localparam logic [31:0] W1 = 32'h0010_0093;  // bytes at 0x004
    localparam logic [31:0] W2 = 32'h0000_12B7;  // bytes at 0x100
    localparam logic [31:0] W3 = 32'h0000_006F;  // bytes at 0xFFFF_FFFC (index 0x3FC)

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ifetch_if bus0 ();
    ifetch_if bus1 ();

    ifetch #(.RESET_PC(32'h0000_0000)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    ifetch #(.RESET_PC(32'hFFFF_FFFC)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    logic [7:0]  mem [0:1023];
    int          tests = 0;
    int          fails = 0;
    logic        req0 = 1'b0;
    logic        req1 = 1'b0;
    logic [31:0] adr0 = '0;
    logic [31:0] adr1 = '0;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        busy;
        logic        br;
        logic [31:0] tgt;
        logic        e_rd;
        logic [31:0] e_a;
        logic        e_vld;
        logic [31:0] e_pc;
        logic [31:0] e_is;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t v(input logic r, input logic s, input logic b, input logic br,
                               input logic [31:0] tgt, input logic rd, input logic [31:0] a,
                               input logic vl, input logic [31:0] pc, input logic [31:0] is);
        vec_t x;
        x.rst = r; x.stall = s; x.busy = b; x.br = br; x.tgt = tgt;
        x.e_rd = rd; x.e_a = a; x.e_vld = vl; x.e_pc = pc; x.e_is = is;
        return x;
    endfunction

    function automatic logic [7:0] mb(input logic [31:0] a);
        return mem[a[9:0]];
    endfunction

    // Architectural view: instruction word is four little-endian bytes at a..a+3 (mod 2^32).
    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {mb(a + 32'd3), mb(a + 32'd2), mb(a + 32'd1), mb(a)};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    // One clock cycle: drive inputs, serve last cycle's memory requests, sample on negedge.
    task automatic step(input logic s, input logic b, input logic br, input logic [31:0] t,
                        input logic r);
        @(posedge clk);
        #1;
        rst = r;
        bus0.stall = s;     bus1.stall = s;
        bus0.mem_busy = b;  bus1.mem_busy = b;
        bus0.br_take = br;  bus1.br_take = br;
        bus0.br_target = t; bus1.br_target = t;
        bus0.mem_din = req0 ? mb(adr0) : 8'($urandom);
        bus1.mem_din = req1 ? mb(adr1) : 8'($urandom);
        @(negedge clk);
        req0 = bus0.mem_rd; adr0 = bus0.mem_a;
        req1 = bus1.mem_rd; adr1 = bus1.mem_a;
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b0, 1'b0, '0, 1'b1);
        chk("rst_vld0", 32'(bus0.vld), 32'd0);
        chk("rst_is0", bus0.is, 32'd0);
        chk("rst_pc0", bus0.pc, 32'h0000_0000);
        chk("rst_rd0", 32'(bus0.mem_rd), 32'd0);
        chk("rst_a0", bus0.mem_a, 32'd0);
        chk("rst_vld1", 32'(bus1.vld), 32'd0);
        chk("rst_pc1", bus1.pc, 32'hFFFF_FFFC);
    endtask

    initial begin
        rst = 1'b1;
        bus0.stall = 1'b0; bus0.mem_busy = 1'b0; bus0.br_take = 1'b0; bus0.br_target = '0;
        bus1.stall = 1'b0; bus1.mem_busy = 1'b0; bus1.br_take = 1'b0; bus1.br_target = '0;
        bus0.mem_din = '0; bus1.mem_din = '0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h13;   mem[1] = 8'h05;   mem[2] = 8'hA0;   mem[3] = 8'h00;
        mem[4] = 8'h93;   mem[5] = 8'h00;   mem[6] = 8'h10;   mem[7] = 8'h00;
        mem[256] = 8'hB7; mem[257] = 8'h12; mem[258] = 8'h00; mem[259] = 8'h00;
        mem[1020] = 8'h6F; mem[1021] = 8'h00; mem[1022] = 8'h00; mem[1023] = 8'h00;

        // Uncontended fetch, three stall cycles, then next word from 0x4.
        vt.push_back(v(1,0,0,0,0, 1,32'h0, 0,0,0));
        vt.push_back(v(0,0,0,0,0, 1,32'h1, 0,0,0));
        vt.push_back(v(0,0,0,0,0, 1,32'h2, 0,0,0));
        vt.push_back(v(0,0,0,0,0, 1,32'h3, 0,0,0));
        vt.push_back(v(0,0,0,0,0, 0,0,     0,0,0));
        vt.push_back(v(0,1,0,0,0, 0,0,     1,32'h0,W0));
        vt.push_back(v(0,1,0,0,0, 0,0,     1,32'h0,W0));
        vt.push_back(v(0,1,0,0,0, 0,0,     1,32'h0,W0));
        vt.push_back(v(0,0,0,0,0, 0,0,     1,32'h0,W0));
        vt.push_back(v(0,0,0,0,0, 1,32'h4, 0,0,0));
        vt.push_back(v(0,0,0,0,0, 1,32'h5, 0,0,0));
        vt.push_back(v(0,0,0,0,0, 1,32'h6, 0,0,0));
        vt.push_back(v(0,0,0,0,0, 1,32'h7, 0,0,0));
        vt.push_back(v(0,0,0,0,0, 0,0,     0,0,0));
        vt.push_back(v(0,1,0,0,0, 0,0,     1,32'h4,W1));
        // mem_busy in cycles 1-2 of the first word.
        vt.push_back(v(1,0,0,0,0, 1,32'h0, 0,0,0));
        vt.push_back(v(0,0,1,0,0, 0,0,     0,0,0));
        vt.push_back(v(0,0,1,0,0, 0,0,     0,0,0));
        vt.push_back(v(0,0,0,0,0, 1,32'h1, 0,0,0));
        vt.push_back(v(0,0,0,0,0, 1,32'h2, 0,0,0));
        vt.push_back(v(0,0,0,0,0, 1,32'h3, 0,0,0));
        vt.push_back(v(0,0,1,0,0, 0,0,     0,0,0));
        vt.push_back(v(0,1,1,0,0, 0,0,     1,32'h0,W0));
        // Redirect to 0x102 in cycle 2 of a fetch.
        vt.push_back(v(1,0,0,0,0,            1,32'h0,   0,0,0));
        vt.push_back(v(0,0,0,0,0,            1,32'h1,   0,0,0));
        vt.push_back(v(0,0,0,1,32'h0000_0102, 0,0,       0,0,0));
        vt.push_back(v(0,0,0,0,0,            1,32'h100, 0,0,0));
        vt.push_back(v(0,0,0,0,0,            1,32'h101, 0,0,0));
        vt.push_back(v(0,0,0,0,0,            1,32'h102, 0,0,0));
        vt.push_back(v(0,0,0,0,0,            1,32'h103, 0,0,0));
        vt.push_back(v(0,0,0,0,0,            0,0,       0,0,0));
        vt.push_back(v(0,1,0,0,0,            0,0,       1,32'h100,W2));
        // Redirect while holding a stalled word.
        vt.push_back(v(1,0,0,0,0,            1,32'h0,   0,0,0));
        vt.push_back(v(0,0,0,0,0,            1,32'h1,   0,0,0));
        vt.push_back(v(0,0,0,0,0,            1,32'h2,   0,0,0));
        vt.push_back(v(0,0,0,0,0,            1,32'h3,   0,0,0));
        vt.push_back(v(0,0,0,0,0,            0,0,       0,0,0));
        vt.push_back(v(0,1,0,0,0,            0,0,       1,32'h0,W0));
        vt.push_back(v(0,1,0,1,32'h0000_0100, 0,0,       1,32'h0,W0));
        vt.push_back(v(0,1,0,0,0,            1,32'h100, 0,0,0));
        vt.push_back(v(0,1,0,0,0,            1,32'h101, 0,0,0));
        vt.push_back(v(0,1,0,0,0,            1,32'h102, 0,0,0));
        vt.push_back(v(0,1,0,0,0,            1,32'h103, 0,0,0));
        vt.push_back(v(0,1,0,0,0,            0,0,       0,0,0));
        vt.push_back(v(0,1,0,0,0,            0,0,       1,32'h100,W2));
        vt.push_back(v(0,0,0,0,0,            0,0,       1,32'h100,W2));
        vt.push_back(v(0,0,0,0,0,            1,32'h104, 0,0,0));

        for (int i = 0; i < vt.size(); i++) begin
            if (vt[i].rst) do_reset();
            step(vt[i].stall, vt[i].busy, vt[i].br, vt[i].tgt, 1'b0);
            chk($sformatf("vec%0d_rd", i), 32'(bus0.mem_rd), 32'(vt[i].e_rd));
            if (vt[i].e_rd) chk($sformatf("vec%0d_a", i), bus0.mem_a, vt[i].e_a);
            chk($sformatf("vec%0d_vld", i), 32'(bus0.vld), 32'(vt[i].e_vld));
            chk($sformatf("vec%0d_is", i), bus0.is, vt[i].e_is);
            if (vt[i].e_vld) chk($sformatf("vec%0d_pc", i), bus0.pc, vt[i].e_pc);
        end

        // RESET_PC at the top of the address space: second word wraps to 0.
        do_reset();
        for (int c = 0; c < 12; c++) begin
            step(1'b0, 1'b0, 1'b0, '0, 1'b0);
            if (c == 0) chk("wrap_a_c0", bus1.mem_a, 32'hFFFF_FFFC);
            if (c == 3) chk("wrap_a_c3", bus1.mem_a, 32'hFFFF_FFFF);
            if (c == 5) begin
                chk("wrap_vld1", 32'(bus1.vld), 32'd1);
                chk("wrap_pc1", bus1.pc, 32'hFFFF_FFFC);
                chk("wrap_is1", bus1.is, W3);
            end
            if (c == 6) chk("wrap_a_c6", bus1.mem_a, 32'h0);
            if (c == 11) begin
                chk("wrap_vld2", 32'(bus1.vld), 32'd1);
                chk("wrap_pc2", bus1.pc, 32'h0);
                chk("wrap_is2", bus1.is, W0);
            end
        end

        // Reset mid-fetch, then reset while holding a word.
        do_reset();
        step(1'b0, 1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, 1'b0, '0, 1'b1);
        chk("rmid_rd_in_rst", 32'(bus0.mem_rd), 32'd0);
        step(1'b0, 1'b0, 1'b0, '0, 1'b0);
        chk("rmid_vld", 32'(bus0.vld), 32'd0);
        chk("rmid_is", bus0.is, 32'd0);
        chk("rmid_pc", bus0.pc, 32'h0);
        chk("rmid_restart_a", bus0.mem_a, 32'h0);
        chk("rmid_restart_rd", 32'(bus0.mem_rd), 32'd1);
        for (int c = 1; c < 6; c++) step(1'b1, 1'b0, 1'b0, '0, 1'b0);
        chk("rmid_word_vld", 32'(bus0.vld), 32'd1);
        chk("rmid_word_is", bus0.is, W0);
        step(1'b1, 1'b0, 1'b0, '0, 1'b1);
        step(1'b1, 1'b0, 1'b0, '0, 1'b1);
        chk("rhold_vld", 32'(bus0.vld), 32'd0);
        chk("rhold_is", bus0.is, 32'd0);
        chk("rhold_pc", bus0.pc, 32'h0);
        chk("rhold_rd", 32'(bus0.mem_rd), 32'd0);

        // Random traffic against an architectural model of the fetch stream.
        do_reset();
        begin
            logic [31:0] exp_fpc;
            logic [31:0] ppc, pis;
            logic        pv, pst, pbr;
            int          req_k, due, words;
            exp_fpc = 32'h0; req_k = 0; due = 0; words = 0;
            pv = 1'b0; pst = 1'b0; pbr = 1'b0; ppc = '0; pis = '0;
            for (int c = 0; c < 3000; c++) begin
                logic        s, b, br, rd, vl, np;
                logic [31:0] t, a, pc, is;
                s  = ($urandom_range(0, 1) == 1);
                b  = ($urandom_range(0, 3) == 0);
                br = ($urandom_range(0, 31) == 0);
                t  = $urandom;
                step(s, b, br, t, 1'b0);
                rd = bus0.mem_rd; a = bus0.mem_a; vl = bus0.vld; pc = bus0.pc; is = bus0.is;
                if (rd) begin
                    chk($sformatf("rnd%0d_req_legal", c), 32'(b || br || vl), 32'd0);
                    chk($sformatf("rnd%0d_req_count", c), 32'(req_k < 4), 32'd1);
                    chk($sformatf("rnd%0d_req_addr", c), a, exp_fpc + 32'(req_k));
                end
                if (!vl && !b && !br && req_k < 4)
                    chk($sformatf("rnd%0d_issue_free", c), 32'(rd), 32'd1);
                if (!vl) chk($sformatf("rnd%0d_bubble", c), is, 32'd0);
                if (pbr) chk($sformatf("rnd%0d_br_vld", c), 32'(vl), 32'd0);
                if (pv && pst && !pbr) begin
                    chk($sformatf("rnd%0d_hold_vld", c), 32'(vl), 32'd1);
                    chk($sformatf("rnd%0d_hold_pc", c), pc, ppc);
                    chk($sformatf("rnd%0d_hold_is", c), is, pis);
                end
                np = vl && !pv;
                chk($sformatf("rnd%0d_vld_timing", c), 32'(np), 32'(due == 1));
                if (np) begin
                    chk($sformatf("rnd%0d_pc", c), pc, exp_fpc);
                    chk($sformatf("rnd%0d_is", c), is, word_at(exp_fpc));
                    words++;
                end
                if (due > 0) due--;
                if (br) begin
                    exp_fpc = t & ~32'h3;
                    req_k = 0;
                    due = 0;
                end else begin
                    if (vl && !s) begin
                        exp_fpc = exp_fpc + 32'd4;
                        req_k = 0;
                    end
                    if (rd) begin
                        req_k++;
                        if (req_k == 4) due = 2;
                    end
                end
                pv = vl; ppc = pc; pis = is; pst = s; pbr = br;
            end
            chk("rnd_words_ge_50", 32'(words >= 50), 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ifetch.md
# ifetch

Instruction fetch stage for the RV32I core. Reads each 32-bit instruction as four little-endian bytes from the shared byte-wide synchronous memory port, then presents `pc`/`is` to the decode stage with a `vld` qualifier. Honours decode back-pressure, yields the memory port to the load/store arbiter, and restarts on a taken branch.

## Interface
- `RESET_PC`, 32'h0000_0000, fetch address after reset
- `clk`  in  1  rising-edge clock
- `rst`  in  1  reset, synchronous, active-high
- `mem_a`  out  32  byte address to memory (combinational)
- `mem_rd`  out  1  read request this cycle (combinational)
- `mem_din`  in  8  read data, valid the cycle after the request
- `mem_busy`  in  1  port granted elsewhere; no request may issue
- `stall`  in  1  decode cannot accept this cycle
- `br_take`  in  1  redirect request, one-cycle pulse
- `br_target`  in  32  redirect address; bits [1:0] forced to 0
- `pc`  out  32  address of presented instruction (registered)
- `is`  out  32  presented instruction word (registered)
- `vld`  out  1  `pc`/`is` valid (registered)

## Operation
- Reset: `pc`=`RESET_PC`, `is`=0, `vld`=0, `mem_rd`=0, `mem_a`=0, state FETCH, `iss_cnt`=0, `rcv_cnt`=0, `pend`=0, `fpc`=`RESET_PC`.
- States: FETCH (issuing/receiving bytes), HOLD (word presented to decode).
- FETCH issue: `mem_rd`=1 when `iss_cnt`<4, `!mem_busy`, `!br_take`; `mem_a`=`fpc`+`iss_cnt`; `iss_cnt`++ and `pend`<=1; otherwise `pend`<=0.
- FETCH receive: if `pend`=1, `mem_din` written to byte lane `rcv_cnt` of the assembly register (lane 0 = bits [7:0]), `rcv_cnt`++.
- When the fourth byte is captured: `is`<=assembled word with `mem_din` as [31:24], `pc`<=`fpc`, `vld`<=1, state HOLD.
- HOLD: `mem_rd`=0. `stall`=1: `pc`/`is`/`vld` hold. `stall`=0: word consumed at the edge; `fpc`<=`fpc`+4, counters cleared, `vld`<=0, `is`<=0, state FETCH.
- `mem_busy` mid-word: issuing pauses; an in-flight byte still captured; resumes at next free cycle without re-fetching bytes already issued.
- `br_take` (priority over `stall`, `mem_busy`, HOLD): `fpc`<=`br_target`&~3, counters and `pend` cleared, `vld`<=0, `is`<=0, state FETCH. Byte returning the next cycle is discarded (`pend`=0). No request issues in the `br_take` cycle.
- `vld`=0 always with `is`=0; decode treats 0 as a bubble.
- Address arithmetic is modulo 2^32; `fpc`+4 from 32'hFFFF_FFFC wraps to 0.

## Timing
- Request in cycle t returns data in cycle t+1.
- Uncontended fetch: requests cycles 0-3, bytes captured at edges ending cycles 1-4, `vld`=1 in cycle 5.
- Steady state with `stall`=0: one instruction per 6 cycles (HOLD cycle then 5 fetch cycles).
- Each `mem_busy` cycle during issue adds one cycle to the latency.
- `br_take` in cycle t: `vld`=0 in t+1, first request to target in t+1, `vld`=1 in t+6 if uncontended.
- `rst` overrides everything at the edge, including mid-word and HOLD.

## Structure
- Shared core package: state enum (FETCH, HOLD), `INSN_BUBBLE`=32'h0, `XLEN`=32.
- One sub-module `ifetch_asm`: 4-byte little-endian assembly register with lane-index write and clear; FSM, counters and `pc` logic stay in `ifetch`.

## Test plan
- Reset, memory 0x00..0x03 = 13,05,A0,00, `stall`=0 -> requests at 0,1,2,3 in cycles 0-3; cycle 5 `vld`=1, `pc`=0, `is`=32'h00A0_0513; next word from 0x4 starts cycle 6.
- `mem_busy`=1 in cycles 1-2 of first fetch -> requests at 0 (c0), 1 (c3), 2 (c4), 3 (c5); `vld`=1 in cycle 7, same `is`.
- `stall`=1 for 3 cycles after `vld` rises -> `pc`/`is` stable 4 cycles, no `mem_rd`; fetch of 0x4 starts the cycle after `stall` drops.
- `br_take` with `br_target`=32'h0000_0102 in cycle 2 -> byte from 0x1 ignored, next request address 0x100 in cycle 3, `vld`=1 cycle 8 with `pc`=0x100.
- `br_take` while in HOLD with `stall`=1 -> `vld`=0 next cycle, stalled word dropped, fetch restarts at target.
- `RESET_PC`=32'hFFFF_FFFC, two instructions -> second `pc`=0; `rst` asserted mid-fetch -> all outputs return to reset values next cycle.
